// File: rtl/ram1_bus_arbiter.sv
// Two-port arbiter sharing the RAM1 SRAM bus and the UART strobes.
// Port 0 (CPU) and port 1 (serial loader) are granted round-robin; each access runs a
// fixed SETUP / STROBE / DONE sequence, with extra wait states for UART handshakes.
// Every output, including the Ram1Data tristate enable, comes straight from a flop.
module ram1_bus_arbiter #(
  parameter int unsigned STROBE_CYC = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  input  logic [17:0] addr0,
  input  logic [17:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        busy,
  output logic [17:0] Ram1Addr,
  inout  wire  [15:0] Ram1Data,
  output logic        Ram1OE,
  output logic        Ram1WE,
  output logic        Ram1EN,
  output logic        rdn,
  output logic        wrn,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre
);

  typedef enum logic [2:0] {
    StIdle, StSetup, StRxWait, StStrobe, StTxWaitTbre, StTxWaitTsre, StDone
  } state_e;

  localparam logic [1:0] OpSramRd = 2'b00;
  localparam logic [1:0] OpSramWr = 2'b01;
  localparam logic [1:0] OpUartRd = 2'b10;
  localparam logic [1:0] OpUartWr = 2'b11;

  state_e      state_q;
  logic        gnt_q;   // port owning the access in flight
  logic        last_q;  // port granted last; reset to 1 so port 0 wins the first tie
  logic [1:0]  op_q;
  logic [2:0]  cnt_q;
  logic        drive_q;
  logic [15:0] dout_q;

  logic        pick;
  logic [1:0]  pick_op;
  logic [17:0] pick_addr;
  logic [15:0] pick_wdata;
  logic [3:0]  strobe_lo;  // {Ram1OE, Ram1WE, rdn, wrn} bits to pull low for op_q
  logic        strobe_last;
  logic [15:0] rd_capture;

  // Round-robin pick: on a tie the port not granted last wins.
  always_comb begin
    pick = req1;
    if (req0 && req1) pick = ~last_q;
    pick_op    = pick ? op1 : op0;
    pick_addr  = pick ? addr1 : addr0;
    pick_wdata = pick ? wdata1 : wdata0;
  end

  // Which strobe the latched op uses; at most one is ever selected.
  always_comb begin
    strobe_lo = 4'b0000;
    unique case (op_q)
      OpSramRd: strobe_lo = 4'b1000;
      OpSramWr: strobe_lo = 4'b0100;
      OpUartRd: strobe_lo = 4'b0010;
      OpUartWr: strobe_lo = 4'b0001;
      default:  strobe_lo = 4'b0000;
    endcase
  end

  assign strobe_last = (cnt_q == 3'(STROBE_CYC - 1));
  assign rd_capture  = op_q[1] ? {8'h00, Ram1Data[7:0]} : Ram1Data;
  assign Ram1Data    = drive_q ? dout_q : 16'hzzzz;

  // Access sequencer; all bus outputs are registered here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      busy     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata0   <= 16'h0000;
      rdata1   <= 16'h0000;
      Ram1Addr <= 18'h00000;
      Ram1OE   <= 1'b1;
      Ram1WE   <= 1'b1;
      Ram1EN   <= 1'b1;
      rdn      <= 1'b1;
      wrn      <= 1'b1;
      drive_q  <= 1'b0;
      dout_q   <= 16'h0000;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      op_q     <= OpSramRd;
      cnt_q    <= 3'd0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            state_q  <= StSetup;
            busy     <= 1'b1;
            gnt_q    <= pick;
            op_q     <= pick_op;
            Ram1Addr <= pick_addr;
            Ram1EN   <= pick_op[1];
            drive_q  <= pick_op[0];
            dout_q   <= pick_op[1] ? {8'h00, pick_wdata[7:0]} : pick_wdata;
          end
        end
        StSetup: begin
          if (op_q == OpUartRd && !data_ready) begin
            state_q <= StRxWait;
          end else begin
            state_q                     <= StStrobe;
            cnt_q                       <= 3'd0;
            {Ram1OE, Ram1WE, rdn, wrn} <= ~strobe_lo;
          end
        end
        StRxWait: begin
          if (data_ready) begin
            state_q                     <= StStrobe;
            cnt_q                       <= 3'd0;
            {Ram1OE, Ram1WE, rdn, wrn} <= ~strobe_lo;
          end
        end
        StStrobe: begin
          if (strobe_last) begin
            {Ram1OE, Ram1WE, rdn, wrn} <= 4'b1111;
            if (!op_q[0]) begin
              if (gnt_q) rdata1 <= rd_capture;
              else       rdata0 <= rd_capture;
            end
            if (op_q == OpUartWr) begin
              // Release the bus while the UART shifts the byte out.
              state_q <= StTxWaitTbre;
              drive_q <= 1'b0;
            end else begin
              state_q <= StDone;
              Ram1EN  <= 1'b1;
              ack0    <= ~gnt_q;
              ack1    <= gnt_q;
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        StTxWaitTbre: begin
          if (tbre) state_q <= StTxWaitTsre;
        end
        StTxWaitTsre: begin
          if (tsre) begin
            state_q <= StDone;
            drive_q <= 1'b1;
            ack0    <= ~gnt_q;
            ack1    <= gnt_q;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          last_q  <= gnt_q;
          drive_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram1_bus_arbiter.sv
// Bench for ram1_bus_arbiter: table of single accesses plus hand-written multi-cycle
// sequences; expected acks are queued when a request is driven and checked on ack.
module tb_ram1_bus_arbiter;

  logic        CLK;
  logic        RST;
  logic        req0, req1;
  logic [1:0]  op0, op1;
  logic [17:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic        busy;
  logic [17:0] Ram1Addr;
  wire  [15:0] Ram1Data;
  logic        Ram1OE, Ram1WE, Ram1EN, rdn, wrn;
  logic        data_ready, tbre, tsre;

  // Second instance with a 3-cycle strobe.
  logic        s3_req0;
  logic        s3_ack0, s3_ack1, s3_busy;
  logic [15:0] s3_rdata0, s3_rdata1;
  logic [17:0] s3_addr;
  wire  [15:0] s3_data;
  logic        s3_oe, s3_we, s3_en, s3_rdn, s3_wrn;

  ram1_bus_arbiter #(.STROBE_CYC(1)) dut (
    .CLK(CLK), .RST(RST), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .Ram1Addr(Ram1Addr), .Ram1Data(Ram1Data), .Ram1OE(Ram1OE), .Ram1WE(Ram1WE),
    .Ram1EN(Ram1EN), .rdn(rdn), .wrn(wrn), .data_ready(data_ready), .tbre(tbre), .tsre(tsre)
  );

  ram1_bus_arbiter #(.STROBE_CYC(3)) dut3 (
    .CLK(CLK), .RST(RST), .req0(s3_req0), .req1(1'b0), .op0(2'b00), .op1(2'b00),
    .addr0(18'h00005), .addr1(18'h00000), .wdata0(16'h0000), .wdata1(16'h0000),
    .ack0(s3_ack0), .ack1(s3_ack1), .rdata0(s3_rdata0), .rdata1(s3_rdata1), .busy(s3_busy),
    .Ram1Addr(s3_addr), .Ram1Data(s3_data), .Ram1OE(s3_oe), .Ram1WE(s3_we),
    .Ram1EN(s3_en), .rdn(s3_rdn), .wrn(s3_wrn), .data_ready(1'b1), .tbre(1'b1), .tsre(1'b1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // SRAM and UART models sharing the bus.
  logic [15:0] mem [256];
  logic [7:0]  rx_byte;
  logic        tb_force;
  logic        tb_drv;
  logic [15:0] tb_val;

  always_comb begin
    tb_drv = 1'b0;
    tb_val = 16'h0000;
    if (tb_force) begin
      tb_drv = 1'b1;
      tb_val = 16'h5AA5;
    end else if (!rdn) begin
      tb_drv = 1'b1;
      tb_val = {8'hEE, rx_byte};
    end else if (!Ram1OE && !Ram1EN) begin
      tb_drv = 1'b1;
      tb_val = mem[Ram1Addr[7:0]];
    end
  end
  assign Ram1Data = tb_drv ? tb_val : 16'hzzzz;
  assign s3_data  = (!s3_oe && !s3_en) ? 16'hC3D2 : 16'hzzzz;

  always @(posedge CLK) if (!Ram1WE && !Ram1EN) mem[Ram1Addr[7:0]] <= Ram1Data;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          port;
    logic        is_read;
    logic [15:0] rdata;
    int          req_cyc;
    int          lat;      // -1: latency not checked
  } exp_t;
  exp_t sb[$];

  logic [17:0] cur_addr;
  logic [15:0] cur_wdata;

  // Scoreboard pop on ack, plus per-cycle bus invariants and strobe widths.
  exp_t mon_e;
  int   w_oe = 0, w_we = 0, w_rd = 0, w_wr = 0;
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (ack0 || ack1) begin
          chk("ack_onehot", {31'b0, ack0 & ack1}, 32'd0);
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: ack0=%0b ack1=%0b with none outstanding", ack0, ack1);
          end else begin
            mon_e = sb.pop_front();
            chk("ack_port", {31'b0, ack1}, mon_e.port);
            if (mon_e.is_read) chk("rdata", ack1 ? rdata1 : rdata0, mon_e.rdata);
            if (mon_e.lat >= 0) chk("latency", cyc - mon_e.req_cyc, mon_e.lat);
          end
        end
        if (!Ram1OE || !Ram1WE) begin
          chk("sram_en_low", Ram1EN, 0);
          chk("uart_strobes_high", {rdn, wrn}, 2'b11);
        end
        if (!rdn || !wrn) chk("uart_en_high", Ram1EN, 1);
        if (!Ram1WE) begin
          chk("we_addr", Ram1Addr, cur_addr);
          chk("we_data", Ram1Data, cur_wdata);
        end
        if (!wrn) chk("wrn_data", Ram1Data, {8'h00, cur_wdata[7:0]});
      end
      if (!Ram1OE) w_oe++; else if (w_oe != 0) begin chk("oe_width", w_oe, 1); w_oe = 0; end
      if (!Ram1WE) w_we++; else if (w_we != 0) begin chk("we_width", w_we, 1); w_we = 0; end
      if (!rdn)    w_rd++; else if (w_rd != 0) begin chk("rdn_width", w_rd, 1); w_rd = 0; end
      if (!wrn)    w_wr++; else if (w_wr != 0) begin chk("wrn_width", w_wr, 1); w_wr = 0; end
    end
  end

  task automatic push_exp(input int port, input logic is_read, input logic [15:0] rd,
                          input int lat);
    exp_t e;
    e.port = port; e.is_read = is_read; e.rdata = rd; e.req_cyc = cyc; e.lat = lat;
    sb.push_back(e);
  endtask

  // Wait (bounded) for n acks from either port, counted at negedges.
  task automatic wait_acks(input int n_acks, input int budget, input string name);
    int n = 0;
    int got = 0;
    while (got < n_acks && n < budget) begin
      @(negedge CLK);
      n++;
      if (ack0 || ack1) got++;
    end
    if (got < n_acks) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d acks expected %0d", name, got, n_acks);
      sb.delete();
    end
  endtask

  // Single access; inputs are scrambled once granted to show they are latched.
  task automatic access(input int port, input logic [1:0] op, input logic [17:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rd, input int lat);
    int   n = 0;
    logic seen = 1'b0;
    @(negedge CLK);
    push_exp(port, !op[0], exp_rd, lat);
    cur_addr  = addr;
    cur_wdata = wdata;
    if (port == 0) begin req0 = 1'b1; op0 = op; addr0 = addr; wdata0 = wdata; end
    else           begin req1 = 1'b1; op1 = op; addr1 = addr; wdata1 = wdata; end
    while (!seen && n < 40) begin
      @(negedge CLK);
      n++;
      if (n == 1) begin
        if (port == 0) begin op0 = ~op; addr0 = ~addr; wdata0 = ~wdata; end
        else           begin op1 = ~op; addr1 = ~addr; wdata1 = ~wdata; end
      end
      seen = (port == 0) ? ack0 : ack1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL access_timeout: port %0d op %0b no ack", port, op);
      sb.delete();
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  typedef struct {
    int          port;
    logic [1:0]  op;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [7:0]  rx;
    logic [15:0] exp_rd;
    int          lat;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int ack_at;
    int oe_cnt;

    vecs[0] = '{0, 2'b01, 18'h00010, 16'hA55A, 8'h00, 16'h0000, 3};
    vecs[1] = '{0, 2'b00, 18'h00010, 16'h0000, 8'h00, 16'hA55A, 3};
    vecs[2] = '{1, 2'b01, 18'h3FF22, 16'h1234, 8'h00, 16'h0000, 3};
    vecs[3] = '{1, 2'b00, 18'h3FF22, 16'h0000, 8'h00, 16'h1234, 3};
    vecs[4] = '{0, 2'b10, 18'h00000, 16'h0000, 8'h5B, 16'h005B, 3};
    vecs[5] = '{1, 2'b11, 18'h00000, 16'hBE77, 8'h00, 16'h0000, 5};
    vecs[6] = '{0, 2'b01, 18'h000FF, 16'h0F0F, 8'h00, 16'h0000, 3};
    vecs[7] = '{1, 2'b00, 18'h000FF, 16'h0000, 8'h00, 16'h0F0F, 3};

    RST = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = 2'b00; op1 = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    data_ready = 1'b1; tbre = 1'b1; tsre = 1'b1; rx_byte = 8'h00; tb_force = 1'b0;
    s3_req0 = 1'b0; cur_addr = '0; cur_wdata = '0;

    // Reset state.
    repeat (3) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {ack0, ack1}, 2'b00);
    chk("rst_rdata", {rdata0, rdata1}, 32'd0);
    chk("rst_strobes", {Ram1OE, Ram1WE, Ram1EN, rdn, wrn}, 5'b11111);
    chk("rst_addr", Ram1Addr, 0);
    RST = 1'b0;

    // Table of single accesses.
    for (int i = 0; i < 8; i++) begin
      rx_byte = vecs[i].rx;
      access(vecs[i].port, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
             vecs[i].lat);
    end

    // Both ports held: grants alternate starting with port 0 (port 1 went last).
    @(negedge CLK);
    push_exp(0, 1'b1, 16'hA55A, 3);
    push_exp(1, 1'b1, 16'h1234, -1);
    push_exp(0, 1'b1, 16'hA55A, -1);
    push_exp(1, 1'b1, 16'h1234, -1);
    req0 = 1'b1; op0 = 2'b00; addr0 = 18'h00010;
    req1 = 1'b1; op1 = 2'b00; addr1 = 18'h3FF22;
    wait_acks(4, 40, "alternate");
    req0 = 1'b0; req1 = 1'b0;

    // UART read waiting on data_ready.
    @(negedge CLK);
    push_exp(1, 1'b1, 16'h003C, 7);
    rx_byte = 8'h3C; data_ready = 1'b0;
    req1 = 1'b1; op1 = 2'b10; addr1 = '0;
    repeat (5) begin
      @(negedge CLK);
      chk("rxwait_rdn", rdn, 1);
      chk("rxwait_en", Ram1EN, 1);
      chk("rxwait_busy", busy, 1);
    end
    data_ready = 1'b1;
    k = 0;
    while (!ack1 && k < 20) begin
      @(negedge CLK);
      k++;
      chk("uart_rd_en", Ram1EN, 1);
    end
    req1 = 1'b0;

    // UART write with slow tbre/tsre handshake.
    @(negedge CLK);
    push_exp(0, 1'b0, 16'h0000, 10);
    cur_wdata = 16'h0041; tbre = 1'b0; tsre = 1'b0;
    req0 = 1'b1; op0 = 2'b11; wdata0 = 16'h0041;
    k = 0;
    while (wrn && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("tx_wrn_seen", wrn, 0);
    repeat (4) @(negedge CLK);
    tbre = 1'b1;
    repeat (3) @(negedge CLK);
    tsre = 1'b1;
    k = 0;
    while (!ack0 && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("tx_ack", ack0, 1);
    req0 = 1'b0;

    // Reset in the middle of an SRAM write strobe.
    @(negedge CLK);
    cur_addr = 18'h00040; cur_wdata = 16'hA55A;
    req0 = 1'b1; op0 = 2'b01; addr0 = 18'h00040; wdata0 = 16'hA55A;
    repeat (2) @(negedge CLK);
    chk("mid_we_low", Ram1WE, 0);
    RST = 1'b1; req0 = 1'b0;
    @(negedge CLK);
    chk("mid_rst_strobes", {Ram1OE, Ram1WE, Ram1EN, rdn, wrn}, 5'b11111);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_acks", {ack0, ack1}, 2'b00);
    chk("mid_rst_rdata", {rdata0, rdata1}, 32'd0);
    chk("mid_rst_addr", Ram1Addr, 0);
    tb_force = 1'b1;
    #1;
    chk("mid_rst_hiz", Ram1Data, 16'h5AA5);
    tb_force = 1'b0;
    RST = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      chk("no_ack_after_rst", {ack0, ack1}, 2'b00);
    end

    // Priority back to port 0 after reset even though port 0 went last before it.
    push_exp(0, 1'b1, 16'hA55A, 3);
    push_exp(1, 1'b1, 16'h0F0F, -1);
    req0 = 1'b1; op0 = 2'b00; addr0 = 18'h00010;
    req1 = 1'b1; op1 = 2'b00; addr1 = 18'h000FF;
    wait_acks(2, 30, "post_rst");
    req0 = 1'b0; req1 = 1'b0;

    // STROBE_CYC = 3 instance: SRAM read.
    @(negedge CLK);
    s3_req0 = 1'b1;
    k = 0; ack_at = -1; oe_cnt = 0;
    while (ack_at < 0 && k < 20) begin
      @(negedge CLK);
      k++;
      if (!s3_oe) oe_cnt++;
      if (s3_ack0) ack_at = k;
    end
    s3_req0 = 1'b0;
    chk("s3_oe_cycles", oe_cnt, 3);
    chk("s3_latency", ack_at, 5);
    chk("s3_rdata", s3_rdata0, 16'hC3D2);

    repeat (3) @(negedge CLK);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
